// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble instruction, inter-stage payload widths
// and the IF/ID payload layout.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

  localparam int unsigned IF_ID_W  = 64;   // pc + instr
  localparam int unsigned ID_EX_W  = 160;  // pc, rs1, rs2, imm, ctrl
  localparam int unsigned EX_MEM_W = 128;  // pc, alu result, store data, ctrl
  localparam int unsigned MEM_WB_W = 96;   // pc, wb data, ctrl

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  // IF/ID bubble: pc of zero with a NOP in the low word.
  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for performance events.
// Ports: clk, rst_n (async active-low), inc (count one event),
//        clr (synchronous clear, wins over inc), value (current count).
module pipe_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;

  // Count until all-ones, then stick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (clr) begin
      value_q <= '0;
    end else if (inc && (value_q != {WIDTH{1'b1}})) begin
      value_q <= value_q + WIDTH'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake.
// SKID_EN=1: two-entry skid buffer, in_ready is a flop output.
// SKID_EN=0: single register, in_ready = !main_valid | out_ready.
// Ports: clk, rst_n (async active-low), flush (synchronous squash),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//        (downstream, out_data is BUBBLE_VAL when not valid),
//        stall_cnt/stall_cnt_clr (saturating count of stalled cycles).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W      = IF_ID_W,
  parameter bit                  SKID_EN     = 1'b1,
  parameter logic [DATA_W-1:0]   BUBBLE_VAL  = DATA_W'(IF_ID_BUBBLE),
  parameter int unsigned         STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_cnt_clr
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic up_xfer;
  logic dn_xfer;

  if (SKID_EN) begin : g_skid
    assign in_ready = !skid_valid_q;
  end else begin : g_noskid
    assign in_ready = !main_valid_q | out_ready;
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_valid_q ? main_data_q : BUBBLE_VAL;
  assign up_xfer   = in_valid & in_ready;
  assign dn_xfer   = main_valid_q & out_ready;

  // Next-state: flush wins, then skid (EMPTY/ONE/FULL) or single-register rules.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID_EN) begin
      if (!main_valid_q) begin
        if (up_xfer) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end
      end else if (!skid_valid_q) begin
        if (up_xfer && !dn_xfer) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end else if (!up_xfer && dn_xfer) begin
          main_valid_d = 1'b0;
        end else if (up_xfer && dn_xfer) begin
          main_data_d  = in_data;
        end
      end else if (dn_xfer) begin
        // Full: skid entry moves forward so ordering is kept.
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else begin
      if (up_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (dn_xfer) begin
        main_valid_d = 1'b0;
      end
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  pipe_sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (main_valid_q & !out_ready),
    .clr   (stall_cnt_clr),
    .value (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no-skid, 4-bit counter)
// share one stimulus stream; a FIFO-style model per instance is compared on
// every falling edge, and directed checks pin key values.
module tb_pipe_stage_reg;

  localparam logic [63:0] BUB = 64'h0000000000000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        stall_cnt_clr = 1'b0;

  logic        ir [3];
  logic        ov [3];
  logic [63:0] od [3];
  logic [15:0] sc_a [3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc4;

  assign sc_a[0] = sc0;
  assign sc_a[1] = sc1;
  assign sc_a[2] = 16'(sc4);

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .SKID_EN(1'b1), .BUBBLE_VAL(BUB), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .stall_cnt(sc0), .stall_cnt_clr(stall_cnt_clr));

  pipe_stage_reg #(.DATA_W(64), .SKID_EN(1'b0), .BUBBLE_VAL(BUB), .STALL_CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .stall_cnt(sc1), .stall_cnt_clr(stall_cnt_clr));

  pipe_stage_reg #(.DATA_W(64), .SKID_EN(1'b1), .BUBBLE_VAL(BUB), .STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .stall_cnt(sc4), .stall_cnt_clr(stall_cnt_clr));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: each instance is a FIFO of capacity 2 (skid) or 1 (plain register).
  int          m_cap  [3] = '{2, 1, 2};
  int          m_smax [3] = '{65535, 65535, 15};
  int          m_cnt  [3] = '{0, 0, 0};
  int          m_sc   [3] = '{0, 0, 0};
  logic [63:0] m_e0   [3] = '{64'h0, 64'h0, 64'h0};
  logic [63:0] m_e1   [3] = '{64'h0, 64'h0, 64'h0};

  function automatic bit m_ready(input int i);
    if (m_cap[i] == 2) return m_cnt[i] < 2;
    return (m_cnt[i] == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0;
        m_sc[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit up, dn;
        up = in_valid && m_ready(i);
        dn = (m_cnt[i] > 0) && out_ready;
        if (stall_cnt_clr) m_sc[i] = 0;
        else if ((m_cnt[i] > 0) && !out_ready && (m_sc[i] < m_smax[i])) m_sc[i]++;
        if (flush) begin
          m_cnt[i] = 0;
        end else begin
          if (dn) begin
            m_e0[i] = m_e1[i];
            m_cnt[i]--;
          end
          if (up) begin
            if (m_cnt[i] == 0) m_e0[i] = in_data;
            else m_e1[i] = in_data;
            m_cnt[i]++;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m%0d.out_valid", i), 64'(ov[i]), 64'(m_cnt[i] > 0));
      chk($sformatf("m%0d.out_data", i), od[i], (m_cnt[i] > 0) ? m_e0[i] : BUB);
      chk($sformatf("m%0d.in_ready", i), 64'(ir[i]), 64'(m_ready(i)));
      chk($sformatf("m%0d.stall_cnt", i), 64'(sc_a[i]), 64'(m_sc[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst.out_valid", 64'(ov[0]), 64'd0);
    chk("rst.out_data", od[0], BUB);
    chk("rst.in_ready", 64'(ir[0]), 64'd1);
    chk("rst.stall_cnt", 64'(sc0), 64'd0);
    rst_n = 1'b1;
    step();

    // Streaming with out_ready=1
    out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      push(64'(v));
      chk("stream.out_data", od[0], 64'(v));
      chk("stream.in_ready", 64'(ir[0]), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream.stall_cnt", 64'(sc0), 64'd0);

    // Backpressure: 10 in main, 11 in skid, 12 held upstream
    out_ready = 1'b0;
    push(64'd10);
    push(64'd11);
    chk("bp.out_data", od[0], 64'd10);
    chk("bp.in_ready", 64'(ir[0]), 64'd0);
    push(64'd12);
    step();
    chk("bp.hold", od[0], 64'd10);
    chk("bp.stall_cnt", 64'(sc0), 64'd3);
    out_ready = 1'b1;
    step();
    chk("bp.rel1", od[0], 64'd11);
    chk("bp.rel1_cnt", 64'(sc0), 64'd3);
    step();
    chk("bp.rel2", od[0], 64'd12);
    in_valid = 1'b0;
    step();
    chk("bp.drained", 64'(ov[0]), 64'd0);

    // Flush while full, with 22 offered in the same cycle
    out_ready = 1'b0;
    push(64'd20);
    push(64'd21);
    chk("fl.full", 64'(ir[0]), 64'd0);
    flush = 1'b1;
    push(64'd22);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl.out_valid", 64'(ov[0]), 64'd0);
    chk("fl.out_data", od[0], BUB);
    chk("fl.in_ready", 64'(ir[0]), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl.no22", 64'(ov[0]), 64'd0);

    // Plain register: simultaneous accept and drain
    out_ready = 1'b0;
    push(64'd30);
    chk("ns.hold30", od[1], 64'd30);
    out_ready = 1'b1;
    in_data = 64'd31;
    #1;
    chk("ns.in_ready", 64'(ir[1]), 64'd1);
    step();
    chk("ns.out31", od[1], 64'd31);
    in_valid = 1'b0;
    step();

    // Async reset pulsed mid-cycle while full
    out_ready = 1'b0;
    push(64'd40);
    push(64'd41);
    in_valid = 1'b0;
    chk("ar.full", 64'(ir[0]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 64'(ov[0]), 64'd0);
    chk("ar.out_data", od[0], BUB);
    chk("ar.stall_cnt", 64'(sc0), 64'd0);
    chk("ar.in_ready", 64'(ir[0]), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    push(64'd50);
    chk("ar.accept", od[0], 64'd50);
    in_valid = 1'b0;
    step();

    // Saturating counter and clear
    out_ready = 1'b0;
    push(64'd60);
    in_valid = 1'b0;
    repeat (20) step();
    chk("cnt.sat4", 64'(sc4), 64'd15);
    chk("cnt.w16", 64'(sc0), 64'd20);
    stall_cnt_clr = 1'b1;
    step();
    stall_cnt_clr = 1'b0;
    chk("cnt.clr4", 64'(sc4), 64'd0);
    chk("cnt.clr16", 64'(sc0), 64'd0);
    step();
    chk("cnt.restart", 64'(sc4), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
